vend_change_disp: RTL and testbench



---
 rtl/vend_pkg.sv | 32 +++
 rtl/vend_change_disp_if.sv | 30 +++
 rtl/vend_ack_timer.sv | 27 ++
 rtl/vend_change_disp.sv | 115 +++++++++++
 tb/tb_vend_change_disp.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending datapath: coin values, coin codes and FSM states.
package vend_pkg;

  localparam int unsigned NICKEL_V  = 1;
  localparam int unsigned DIME_V    = 2;
  localparam int unsigned QUARTER_V = 5;

  typedef enum logic [1:0] {
    CoinNone = 2'd0,
    CoinN    = 2'd1,
    CoinD    = 2'd2,
    CoinQ    = 2'd3
  } coin_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StSel  = 3'd1,
    StFire = 3'd2,
    StWait = 3'd3,
    StFin  = 3'd4
  } state_e;

  function automatic int unsigned coin_value(coin_e c);
    case (c)
      CoinQ:   return QUARTER_V;
      CoinD:   return DIME_V;
      CoinN:   return NICKEL_V;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_disp_if.sv
// Request, tube-sensor and hopper handshake bundle for the change dispenser.
interface vend_change_disp_if #(
  parameter int unsigned AMT_W = 4
) ();

  logic             req;
  logic [AMT_W-1:0] amt;
  logic             q_empty;
  logic             d_empty;
  logic             n_empty;
  logic             hop_ack;
  logic             busy;
  logic             pay_q;
  logic             pay_d;
  logic             pay_n;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] remain;

  modport master (
    output req, amt, q_empty, d_empty, n_empty, hop_ack,
    input  busy, pay_q, pay_d, pay_n, done, short, remain
  );

  modport slave (
    input  req, amt, q_empty, d_empty, n_empty, hop_ack,
    output busy, pay_q, pay_d, pay_n, done, short, remain
  );

endinterface

// File: rtl/vend_ack_timer.sv
// Clear/enable up-counter; tc flags the enabled cycle whose increment reaches Limit-1.
module vend_ack_timer #(
  parameter int unsigned Limit = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = (Limit > 2) ? $clog2(Limit) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Caller qualifies with its own enable; this keeps tc free of a combinational path from en.
  assign tc = (cnt_q == CntW'(Limit - 2));

endmodule

// File: rtl/vend_change_disp.sv
// Greedy coin-by-coin change payout through a three-tube hopper with per-coin ack timeout.
module vend_change_disp
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W  = 4,
  parameter int unsigned ACK_TO = 16
) (
  input logic               clk,
  input logic               reset,
  vend_change_disp_if.slave bus
);

  state_e           state_q, state_d;
  coin_e            coin_q, coin_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_tc;

  vend_ack_timer #(
    .Limit (ACK_TO)
  ) u_ack_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      coin_q  <= CoinNone;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      coin_q  <= coin_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    coin_d  = coin_q;
    rem_d   = rem_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          rem_d   = bus.amt;
          state_d = StSel;
        end
      end
      StSel: begin
        // Guards guarantee rem >= coin value, so the later subtraction cannot underflow.
        if (rem_q >= AMT_W'(QUARTER_V) && !bus.q_empty) begin
          coin_d  = CoinQ;
          state_d = StFire;
        end else if (rem_q >= AMT_W'(DIME_V) && !bus.d_empty) begin
          coin_d  = CoinD;
          state_d = StFire;
        end else if (rem_q >= AMT_W'(NICKEL_V) && !bus.n_empty) begin
          coin_d  = CoinN;
          state_d = StFire;
        end else begin
          coin_d  = CoinNone;
          state_d = StFin;
        end
      end
      StFire: begin
        tmr_clr = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (bus.hop_ack) begin
          rem_d   = rem_q - AMT_W'(coin_value(coin_q));
          state_d = StSel;
        end else begin
          tmr_en = 1'b1;
          if (tmr_tc) begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.busy   = (state_q != StIdle);
    bus.pay_q  = 1'b0;
    bus.pay_d  = 1'b0;
    bus.pay_n  = 1'b0;
    bus.done   = 1'b0;
    bus.short  = 1'b0;
    bus.remain = '0;
    if (state_q == StFire) begin
      bus.pay_q = (coin_q == CoinQ);
      bus.pay_d = (coin_q == CoinD);
      bus.pay_n = (coin_q == CoinN);
    end
    if (state_q == StFin) begin
      bus.done   = 1'b1;
      bus.short  = (rem_q != '0);
      bus.remain = rem_q;
    end
  end

endmodule

// File: tb/tb_vend_change_disp.sv
// Self-checking bench for vend_change_disp: vector table, hopper responder and event scoreboard.
module tb_vend_change_disp;

  localparam int unsigned AMT_W  = 4;
  localparam int unsigned ACK_TO = 16;
  localparam int C_N = 1;
  localparam int C_D = 2;
  localparam int C_Q = 3;

  typedef struct {
    int       amt;
    bit       qe;
    bit       de;
    bit       ne;
    int       ack_dly;  // 0 = hopper never acks
    int       npay;
    bit [7:0] pays;     // 2-bit coin codes, first coin in bits [1:0]
    bit       shrt;
    int       rem;
  } vec_t;

  typedef struct {
    bit is_done;
    int coin;
    bit shrt;
    int rem;
  } ev_t;

  logic clk = 1'b0;
  logic reset;

  vend_change_disp_if #(.AMT_W(AMT_W)) bus ();

  vend_change_disp #(
    .AMT_W  (AMT_W),
    .ACK_TO (ACK_TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  errors  = 0;
  int  checks  = 0;
  int  ack_dly = 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [7:0] seq(input int a, input int b, input int c, input int d);
    bit [1:0] ca, cb, cc, cd;
    ca = a[1:0];
    cb = b[1:0];
    cc = c[1:0];
    cd = d[1:0];
    return {cd, cc, cb, ca};
  endfunction

  task automatic push_pay(input int c);
    ev_t e;
    e.is_done = 1'b0;
    e.coin    = c;
    e.shrt    = 1'b0;
    e.rem     = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input bit s, input int r);
    ev_t e;
    e.is_done = 1'b1;
    e.coin    = 0;
    e.shrt    = s;
    e.rem     = r;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every pay pulse and done pulse.
  initial begin : monitor
    bit  prev_pay;
    int  npay;
    int  coin;
    ev_t e;
    prev_pay = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        npay = int'(bus.pay_q) + int'(bus.pay_d) + int'(bus.pay_n);
        chk("pay_onehot", int'(npay <= 1), 1);
        if (npay != 0) chk("pay_back_to_back", int'(prev_pay), 0);
        prev_pay = (npay != 0);
        if (!bus.done) chk("remain_short_without_done", int'({bus.short, bus.remain}), 0);
        if (npay == 1) begin
          coin = bus.pay_q ? C_Q : (bus.pay_d ? C_D : C_N);
          if (exp_q.size() == 0) begin
            chk("unexpected_pay", coin, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pay_vs_done_order", int'(e.is_done), 0);
            chk("pay_coin", coin, e.coin);
          end
        end
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("done_vs_pay_order", int'(e.is_done), 1);
            chk("done_short", int'(bus.short), int'(e.shrt));
            chk("done_remain", int'(bus.remain), e.rem);
          end
        end
      end else begin
        prev_pay = 1'b0;
      end
    end
  end

  // Hopper model: acks ack_dly cycles after each pay pulse.
  initial begin : hopper
    int cnt;
    cnt = 0;
    bus.hop_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.hop_ack = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.hop_ack = 1'b1;
      end
      if ((bus.pay_q || bus.pay_d || bus.pay_n) && ack_dly > 0) cnt = ack_dly;
    end
  end

  task automatic set_tubes(input bit qe, input bit de, input bit ne);
    bus.q_empty = qe;
    bus.d_empty = de;
    bus.n_empty = ne;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(bus.done), 1);
  endtask

  task automatic finish_txn();
    @(negedge clk);
    chk("busy_after_done", int'(bus.busy), 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    set_tubes(v.qe, v.de, v.ne);
    ack_dly = v.ack_dly;
    for (int i = 0; i < v.npay; i++) push_pay(int'(v.pays[2*i +: 2]));
    push_done(v.shrt, v.rem);
    bus.req = 1'b1;
    bus.amt = AMT_W'(v.amt);
    @(negedge clk);
    bus.req = 1'b0;
    wait_done("vec_done_seen");
    finish_txn();
  endtask

  // amt with no payable coin: done exactly two cycles after req.
  task automatic run_lat2(input int a, input bit qe, input bit de, input bit ne,
                          input bit s, input int r);
    @(negedge clk);
    set_tubes(qe, de, ne);
    push_done(s, r);
    bus.req = 1'b1;
    bus.amt = AMT_W'(a);
    @(negedge clk);
    bus.req = 1'b0;
    chk("lat2_busy_in_sel", int'(bus.busy), 1);
    chk("lat2_no_early_done", int'(bus.done), 0);
    @(negedge clk);
    chk("lat2_done", int'(bus.done), 1);
    finish_txn();
  endtask

  vec_t vecs[12];

  initial begin
    int n;
    reset   = 1'b1;
    bus.req = 1'b0;
    bus.amt = '0;
    set_tubes(1'b0, 1'b0, 1'b0);

    vecs[0]  = '{8,  0, 0, 0, 1,  3, seq(C_Q, C_D, C_N, 0),   0, 0};
    vecs[1]  = '{5,  1, 0, 0, 1,  3, seq(C_D, C_D, C_N, 0),   0, 0};
    vecs[2]  = '{15, 0, 0, 0, 1,  3, seq(C_Q, C_Q, C_Q, 0),   0, 0};
    vecs[3]  = '{4,  0, 0, 1, 1,  2, seq(C_D, C_D, 0, 0),     0, 0};
    vecs[4]  = '{3,  0, 1, 1, 1,  0, seq(0, 0, 0, 0),         1, 3};
    vecs[5]  = '{7,  0, 1, 0, 1,  3, seq(C_Q, C_N, C_N, 0),   0, 0};
    vecs[6]  = '{7,  0, 0, 0, 5,  2, seq(C_Q, C_D, 0, 0),     0, 0};
    vecs[7]  = '{2,  0, 0, 0, 15, 1, seq(C_D, 0, 0, 0),       0, 0};
    vecs[8]  = '{2,  0, 0, 0, 16, 1, seq(C_D, 0, 0, 0),       1, 2};
    vecs[9]  = '{1,  0, 0, 1, 1,  0, seq(0, 0, 0, 0),         1, 1};
    vecs[10] = '{12, 0, 0, 0, 1,  3, seq(C_Q, C_Q, C_D, 0),   0, 0};
    vecs[11] = '{3,  1, 1, 0, 1,  3, seq(C_N, C_N, C_N, 0),   0, 0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({bus.busy, bus.pay_q, bus.pay_d, bus.pay_n,
                               bus.done, bus.short, bus.remain}), 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    run_lat2(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_lat2(3, 1'b1, 1'b1, 1'b1, 1'b1, 3);

    // No ack: done 16 cycles after the pay cycle; a req while busy must be ignored.
    @(negedge clk);
    set_tubes(1'b0, 1'b0, 1'b0);
    ack_dly = 0;
    push_pay(C_Q);
    push_done(1'b1, 6);
    bus.req = 1'b1;
    bus.amt = AMT_W'(6);
    @(negedge clk);
    bus.req = 1'b0;
    n = 0;
    while (!bus.pay_q && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_pay_seen", int'(bus.pay_q), 1);
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        bus.req = 1'b1;
        bus.amt = AMT_W'(2);
      end
      if (n == 4) bus.req = 1'b0;
    end
    chk("timeout_latency", n, 16);
    finish_txn();

    // Reset while waiting on the first coin: everything drops, nothing more is paid.
    @(negedge clk);
    ack_dly = 1;
    push_pay(C_Q);
    bus.req = 1'b1;
    bus.amt = AMT_W'(7);
    @(negedge clk);
    bus.req = 1'b0;
    n = 0;
    while (!bus.pay_q && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reset_mid_pay_seen", int'(bus.pay_q), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_outputs", int'({bus.busy, bus.pay_q, bus.pay_d, bus.pay_n,
                                   bus.done, bus.short, bus.remain}), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_mid_idle", int'(bus.busy), 0);
    chk("reset_mid_no_more_events", exp_q.size(), 0);
    exp_q.delete();
    run_vec('{2, 0, 0, 0, 1, 1, seq(C_D, 0, 0, 0), 0, 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
